// File: rtl/phase_meas_ctrl_pkg.sv
// Shared types and default sizing for the phase/period measurement controller.
package phase_meas_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ARM  = 2'd1;
  localparam state_t MEAS = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam int DEF_CNT_W    = 28;
  localparam int DEF_AVG_LOG2 = 4;
  localparam int DEF_TIMEOUT  = 200_000_000;
  localparam int SUM_W        = DEF_CNT_W + DEF_AVG_LOG2;

endpackage

// File: rtl/phase_meas_ctrl_if.sv
// Host-side request/result bundle of the measurement controller.
interface phase_meas_ctrl_if #(
  parameter int CNT_W    = 28,
  parameter int AVG_LOG2 = 4
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      timeout_err;
  logic [CNT_W+AVG_LOG2-1:0] period_sum;
  logic [CNT_W+AVG_LOG2-1:0] delay_sum;
  logic [CNT_W-1:0]          period_avg;
  logic [CNT_W-1:0]          delay_avg;

  modport master (
    output start,
    input  busy, done, timeout_err, period_sum, delay_sum, period_avg, delay_avg
  );

  modport slave (
    input  start,
    output busy, done, timeout_err, period_sum, delay_sum, period_avg, delay_avg
  );
endinterface

// File: rtl/phase_meas_ctrl_edge_sync.sv
// Two-flop synchroniser plus last-value flop; rise is a 1-cycle pulse per rising edge.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s1_q, s2_q, last_q;
  logic s1_d, s2_d, last_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    last_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      last_q <= last_d;
    end
  end

  assign rise = s2_q & ~last_q;
endmodule

// File: rtl/phase_meas_ctrl.sv
// Times 2^AVG_LOG2 ref periods and ref->test delays, reporting sums, averages and done.
module phase_meas_ctrl
  import phase_meas_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk_400M,
  input  logic             rst_n,
  input  logic             sig_ref,
  input  logic             sig_test,
  phase_meas_ctrl_if.slave host
);
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int ITER_W = AVG_LOG2 + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  T_LAST    = TMR_W'(TIMEOUT - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'((1 << AVG_LOG2) - 1);

  logic ref_rise, test_rise;

  edge_sync u_ref_sync  (.clk(clk_400M), .rst_n(rst_n), .din(sig_ref),  .rise(ref_rise));
  edge_sync u_test_sync (.clk(clk_400M), .rst_n(rst_n), .din(sig_test), .rise(test_rise));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] avg_of(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] sh;
    sh = s >> AVG_LOG2;
    return sh[CNT_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tmo_err_q, tmo_err_d;
  logic               got_test_q, got_test_d;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [CNT_W-1:0]   dly_lat_q, dly_lat_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [ACC_W-1:0]   per_acc_q, per_acc_d;
  logic [ACC_W-1:0]   dly_acc_q, dly_acc_d;
  logic [ACC_W-1:0]   per_sum_q, per_sum_d;
  logic [ACC_W-1:0]   dly_sum_q, dly_sum_d;
  logic [CNT_W-1:0]   per_avg_q, per_avg_d;
  logic [CNT_W-1:0]   dly_avg_q, dly_avg_d;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmo_err_d  = tmo_err_q;
    got_test_d = got_test_q;
    per_cnt_d  = per_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    dly_lat_d  = dly_lat_q;
    timer_d    = timer_q;
    iter_d     = iter_q;
    per_acc_d  = per_acc_q;
    dly_acc_d  = dly_acc_q;
    per_sum_d  = per_sum_q;
    dly_sum_d  = dly_sum_q;
    per_avg_d  = per_avg_q;
    dly_avg_d  = dly_avg_q;

    case (state_q)
      IDLE: begin
        if (host.start) begin
          state_d   = ARM;
          busy_d    = 1'b1;
          per_acc_d = '0;
          dly_acc_d = '0;
          iter_d    = '0;
          timer_d   = '0;
          tmo_err_d = 1'b0;
        end
      end

      ARM: begin
        if (ref_rise) begin
          state_d    = MEAS;
          per_cnt_d  = CNT_W'(1);
          dly_cnt_d  = '0;
          got_test_d = 1'b0;
          timer_d    = '0;
        end else if (timer_q == T_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          tmo_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      MEAS: begin
        per_cnt_d = sat_inc(per_cnt_q);
        dly_cnt_d = sat_inc(dly_cnt_q);
        timer_d   = timer_q + TMR_W'(1);
        // Latch the post-increment count so a test edge k cycles after ref reads k.
        if (test_rise && !got_test_q) begin
          dly_lat_d  = dly_cnt_d;
          got_test_d = 1'b1;
        end
        if (ref_rise) begin
          if (got_test_q) begin
            per_acc_d = per_acc_q + ACC_W'(per_cnt_q);
            dly_acc_d = dly_acc_q + ACC_W'(dly_lat_q);
            iter_d    = iter_q + ITER_W'(1);
            if (iter_q == LAST_ITER) state_d = DONE;
          end
          // A coincident test edge opens the new period with zero delay.
          per_cnt_d  = CNT_W'(1);
          dly_cnt_d  = '0;
          got_test_d = test_rise;
          dly_lat_d  = '0;
          timer_d    = '0;
        end else if (timer_q == T_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          tmo_err_d = 1'b1;
        end
      end

      DONE: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        per_sum_d = per_acc_q;
        dly_sum_d = dly_acc_q;
        per_avg_d = avg_of(per_acc_q);
        dly_avg_d = avg_of(dly_acc_q);
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_400M) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      got_test_q <= 1'b0;
      per_cnt_q  <= '0;
      dly_cnt_q  <= '0;
      dly_lat_q  <= '0;
      timer_q    <= '0;
      iter_q     <= '0;
      per_acc_q  <= '0;
      dly_acc_q  <= '0;
      per_sum_q  <= '0;
      dly_sum_q  <= '0;
      per_avg_q  <= '0;
      dly_avg_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_err_q  <= tmo_err_d;
      got_test_q <= got_test_d;
      per_cnt_q  <= per_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      dly_lat_q  <= dly_lat_d;
      timer_q    <= timer_d;
      iter_q     <= iter_d;
      per_acc_q  <= per_acc_d;
      dly_acc_q  <= dly_acc_d;
      per_sum_q  <= per_sum_d;
      dly_sum_q  <= dly_sum_d;
      per_avg_q  <= per_avg_d;
      dly_avg_q  <= dly_avg_d;
    end
  end

  assign host.busy        = busy_q;
  assign host.done        = done_q;
  assign host.timeout_err = tmo_err_q;
  assign host.period_sum  = per_sum_q;
  assign host.delay_sum   = dly_sum_q;
  assign host.period_avg  = per_avg_q;
  assign host.delay_avg   = dly_avg_q;
endmodule

// File: tb/tb_phase_meas_ctrl.sv
// Directed bench for phase_meas_ctrl: periodic ref/test generator and per-scenario tasks.
module tb_phase_meas_ctrl;
  localparam int CNT_W    = 28;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_ref = 1'b0;
  logic sig_test = 1'b0;

  phase_meas_ctrl_if #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2)) hif ();

  phase_meas_ctrl #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk_400M (clk),
    .rst_n    (rst_n),
    .sig_ref  (sig_ref),
    .sig_test (sig_test),
    .host     (hif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  bit gen_en = 1'b0;
  int gen_p = 100;
  int gen_lag = 25;
  int gen_ph = 0;
  int gen_per = 0;
  int gen_mask = -1;

  // Periodic stimulus: ref high for the first half of each period, test is ref delayed by gen_lag.
  initial begin
    int tph;
    forever begin
      @(negedge clk);
      if (gen_en) begin
        gen_ph = gen_ph + 1;
        if (gen_ph >= gen_p) begin
          gen_ph = 0;
          gen_per = gen_per + 1;
        end
        sig_ref = (gen_ph < gen_p / 2);
        tph = gen_ph - gen_lag;
        if (tph < 0) tph = tph + gen_p;
        sig_test = (tph < gen_p / 2) && (gen_per != gen_mask);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (hif.done === 1'b1) done_cnt = done_cnt + 1;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
  endtask

  // Starts away from a ref edge so the next ref rise is the arming edge; returns that period index base.
  task automatic start_meas(output int per0);
    int i;
    i = 0;
    while (gen_ph != 10 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    per0 = gen_per;
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (hif.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    hif.start = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", hif.busy); end
    checks++; if (hif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", hif.done); end
    checks++; if (hif.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %0b exp 0", hif.timeout_err); end
    checks++; if (hif.period_sum !== '0) begin errors++; $display("FAIL reset_psum got %0d exp 0", hif.period_sum); end
    checks++; if (hif.delay_sum !== '0) begin errors++; $display("FAIL reset_dsum got %0d exp 0", hif.delay_sum); end
    checks++; if (hif.period_avg !== '0) begin errors++; $display("FAIL reset_pavg got %0d exp 0", hif.period_avg); end
    checks++; if (hif.delay_avg !== '0) begin errors++; $display("FAIL reset_davg got %0d exp 0", hif.delay_avg); end
  endtask

  task automatic test_basic();
    int per0;
    bit ok;
    gen_p = 100; gen_lag = 25; gen_mask = -1; gen_en = 1'b1;
    repeat (250) @(negedge clk);
    start_meas(per0);
    checks++; if (hif.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", hif.busy); end
    wait_done(1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done got %0b exp 1", ok); end
    checks++; if (gen_per - per0 !== 5) begin errors++; $display("FAIL basic_nper got %0d exp 5", gen_per - per0); end
    checks++; if (hif.period_sum !== 30'd400) begin errors++; $display("FAIL basic_psum got %0d exp 400", hif.period_sum); end
    checks++; if (hif.delay_sum !== 30'd100) begin errors++; $display("FAIL basic_dsum got %0d exp 100", hif.delay_sum); end
    checks++; if (hif.period_avg !== 28'd100) begin errors++; $display("FAIL basic_pavg got %0d exp 100", hif.period_avg); end
    checks++; if (hif.delay_avg !== 28'd25) begin errors++; $display("FAIL basic_davg got %0d exp 25", hif.delay_avg); end
    @(negedge clk);
    checks++; if (hif.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", hif.done); end
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %0b exp 0", hif.busy); end
  endtask

  task automatic test_timeout();
    int cnt;
    int dbase;
    gen_en = 1'b0;
    @(negedge clk);
    sig_ref = 1'b0;
    sig_test = 1'b0;
    repeat (10) @(negedge clk);
    dbase = done_cnt;
    pulse_start();
    cnt = 0;
    while (hif.busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt !== 1000) begin errors++; $display("FAIL tmo_busy_cycles got %0d exp 1000", cnt); end
    checks++; if (hif.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %0b exp 1", hif.timeout_err); end
    repeat (5) @(negedge clk);
    checks++; if (done_cnt - dbase !== 0) begin errors++; $display("FAIL tmo_no_done got %0d exp 0", done_cnt - dbase); end
    checks++; if (hif.period_sum !== 30'd400) begin errors++; $display("FAIL tmo_psum_hold got %0d exp 400", hif.period_sum); end
  endtask

  task automatic test_missing_edge();
    int per0;
    bit ok;
    gen_p = 100; gen_lag = 25; gen_mask = -1; gen_en = 1'b1;
    repeat (250) @(negedge clk);
    start_meas(per0);
    gen_mask = per0 + 2;
    checks++; if (hif.timeout_err !== 1'b0) begin errors++; $display("FAIL miss_tmo_clear got %0b exp 0", hif.timeout_err); end
    wait_done(1200, ok);
    gen_mask = -1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL miss_done got %0b exp 1", ok); end
    checks++; if (gen_per - per0 !== 6) begin errors++; $display("FAIL miss_nper got %0d exp 6", gen_per - per0); end
    checks++; if (hif.period_sum !== 30'd400) begin errors++; $display("FAIL miss_psum got %0d exp 400", hif.period_sum); end
    checks++; if (hif.delay_sum !== 30'd100) begin errors++; $display("FAIL miss_dsum got %0d exp 100", hif.delay_sum); end
  endtask

  task automatic test_coincident();
    int per0;
    bit ok;
    gen_p = 80; gen_lag = 0; gen_mask = -1; gen_en = 1'b1;
    repeat (250) @(negedge clk);
    start_meas(per0);
    wait_done(1200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL coin_done got %0b exp 1", ok); end
    checks++; if (hif.period_sum !== 30'd320) begin errors++; $display("FAIL coin_psum got %0d exp 320", hif.period_sum); end
    checks++; if (hif.delay_sum !== 30'd0) begin errors++; $display("FAIL coin_dsum got %0d exp 0", hif.delay_sum); end
    checks++; if (hif.period_avg !== 28'd80) begin errors++; $display("FAIL coin_pavg got %0d exp 80", hif.period_avg); end
  endtask

  task automatic test_reset_mid();
    int per0;
    int dbase;
    int i;
    bit ok;
    gen_p = 100; gen_lag = 25; gen_mask = -1; gen_en = 1'b1;
    repeat (250) @(negedge clk);
    start_meas(per0);
    i = 0;
    while (gen_per - per0 < 3 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    repeat (20) @(negedge clk);
    dbase = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b exp 0", hif.busy); end
    checks++; if (hif.period_sum !== '0) begin errors++; $display("FAIL rmid_psum got %0d exp 0", hif.period_sum); end
    checks++; if (hif.delay_sum !== '0) begin errors++; $display("FAIL rmid_dsum got %0d exp 0", hif.delay_sum); end
    checks++; if (hif.period_avg !== '0) begin errors++; $display("FAIL rmid_pavg got %0d exp 0", hif.period_avg); end
    checks++; if (hif.delay_avg !== '0) begin errors++; $display("FAIL rmid_davg got %0d exp 0", hif.delay_avg); end
    repeat (600) @(negedge clk);
    checks++; if (done_cnt - dbase !== 0) begin errors++; $display("FAIL rmid_no_done got %0d exp 0", done_cnt - dbase); end
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got %0b exp 0", hif.busy); end
    start_meas(per0);
    wait_done(1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_redo_done got %0b exp 1", ok); end
    checks++; if (hif.period_sum !== 30'd400) begin errors++; $display("FAIL rmid_redo_psum got %0d exp 400", hif.period_sum); end
    checks++; if (hif.delay_avg !== 28'd25) begin errors++; $display("FAIL rmid_redo_davg got %0d exp 25", hif.delay_avg); end
  endtask

  task automatic test_start_busy();
    int per0;
    int dbase;
    bit ok;
    gen_p = 100; gen_lag = 25; gen_mask = -1; gen_en = 1'b1;
    repeat (250) @(negedge clk);
    dbase = done_cnt;
    start_meas(per0);
    for (int k = 0; k < 12; k++) begin
      repeat (31) @(negedge clk);
      if (hif.busy === 1'b1) begin
        hif.start = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
      end
    end
    wait_done(1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sbusy_done got %0b exp 1", ok); end
    checks++; if (hif.period_sum !== 30'd400) begin errors++; $display("FAIL sbusy_psum got %0d exp 400", hif.period_sum); end
    repeat (800) @(negedge clk);
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL sbusy_done_count got %0d exp 1", done_cnt - dbase); end
    checks++; if (hif.timeout_err !== 1'b0) begin errors++; $display("FAIL sbusy_tmo got %0b exp 0", hif.timeout_err); end
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL sbusy_idle got %0b exp 0", hif.busy); end
  endtask

  initial begin
    hif.start = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_missing_edge();
    test_coincident();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
